img_window_gen: RTL and testbench

Parametrised K×K sliding-window generator for the streaming image-filter datapath. It sits between the pixel input stream and the convolution/MAC stage. It buffers incoming raster pixels in NLB circular line buffers and emits one K×K window per output pixel with valid/ready backpressure. It pulses an interrupt each time a line buffer is retired so the host can push the next line. It generalises the fixed 3×3, 8-bit, 512-wide, 4-buffer controller in width, depth, kernel size and edge handling.

---
 rtl/img_window_gen.sv | 175 +++++++++++++++++
 tb/tb_img_window_gen.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_window_gen.sv
// KxK sliding-window generator over NLB circular line buffers, valid/ready out.
// Define IMGWIN_ZERO_PAD_EN for horizontal zero padding (IMG_W windows per line).
module img_window_gen #(
    parameter int DW    = 8,
    parameter int IMG_W = 512,
    parameter int K     = 3,
    parameter int NLB   = K + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [DW-1:0]            i_data,
    output logic                     o_in_ready,
    output logic                     o_win_valid,
    output logic [K*K*DW-1:0]        o_win_data,
    input  logic                     i_win_ready,
    output logic                     o_intr,
    output logic [$clog2(NLB+1)-1:0] o_lines,
    output logic                     o_ovf
);
    localparam int AW = $clog2(IMG_W);
    localparam int LW = (NLB > 1) ? $clog2(NLB) : 1;
    localparam int CW = $clog2(NLB + 1);
    localparam int RW = $clog2(IMG_W + K);
`ifdef IMGWIN_ZERO_PAD_EN
    localparam int RC_LAST  = IMG_W - 1 + K / 2;
    localparam int EMIT_MIN = K / 2;
`else
    localparam int RC_LAST  = IMG_W - 1;
    localparam int EMIT_MIN = K - 1;
`endif

    typedef enum logic [1:0] {IDLE, PRIME, RUN, RETIRE} state_t;

    function automatic logic [LW-1:0] lb_add(input logic [LW-1:0] lb, input int n);
        int s;
        s = int'(lb) + n;
        if (s >= NLB) s = s - NLB;
        return LW'(s);
    endfunction

    logic [DW-1:0]     mem_q [NLB][IMG_W];
    logic [AW-1:0]     wr_ptr_q;
    logic [LW-1:0]     wr_lb_q;
    logic [LW-1:0]     rd_lb_q;
    logic [CW-1:0]     lines_q;
    logic              ovf_q;
    logic              accept;
    logic              line_done;
    logic              retire;

    state_t            state_q, state_d;
    logic [RW-1:0]     rc_q, rc_d;
    logic              issue;
    logic              en;
    logic [AW-1:0]     rd_col;
    logic [LW-1:0]     rd_idx [K];

    logic              s1_vld_q, s1_emit_q, s1_pad_q, s1_last_q;
    logic [DW-1:0]     s1_col_q [K];
    logic [K*K*DW-1:0] win_q, win_d;
    logic              win_vld_q, win_last_q, intr_q;

    assign o_in_ready = (lines_q < CW'(NLB));
    assign accept     = i_valid && o_in_ready;
    assign line_done  = accept && (wr_ptr_q == AW'(IMG_W - 1));
    assign retire     = (state_q == RETIRE);
    assign en         = !win_vld_q || i_win_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            wr_lb_q  <= '0;
            lines_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) wr_ptr_q <= line_done ? '0 : wr_ptr_q + AW'(1);
            if (line_done) wr_lb_q <= lb_add(wr_lb_q, 1);
            // a line landing in the retire cycle leaves the count unchanged
            if (line_done && !retire) lines_q <= lines_q + CW'(1);
            else if (!line_done && retire) lines_q <= lines_q - CW'(1);
            if (i_valid && !o_in_ready) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < K; r++) rd_idx[r] = lb_add(rd_lb_q, r);
        rd_col = (rc_q < RW'(IMG_W)) ? rc_q[AW-1:0] : '0;
    end

    // buffer RAM and its registered read port carry no reset
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_lb_q][wr_ptr_q] <= i_data;
        if (en) begin
            for (int r = 0; r < K; r++) s1_col_q[r] <= mem_q[rd_idx[r]][rd_col];
        end
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: if (lines_q >= CW'(K)) state_d = PRIME;
            PRIME: begin
                if (en) begin
                    issue   = 1'b1;
                    rc_d    = RW'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en && rc_q <= RW'(RC_LAST)) begin
                    issue = 1'b1;
                    rc_d  = rc_q + RW'(1);
                end
                if (win_vld_q && i_win_ready && win_last_q) state_d = RETIRE;
            end
            RETIRE: begin
                rc_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        win_d = win_q;
        if (state_q == PRIME) begin
            win_d = '0;
        end else if (s1_vld_q) begin
            for (int r = 0; r < K; r++) begin
                for (int j = 0; j < K - 1; j++)
                    win_d[(r*K+j)*DW +: DW] = win_q[(r*K+j+1)*DW +: DW];
                win_d[(r*K+K-1)*DW +: DW] = s1_pad_q ? '0 : s1_col_q[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rc_q       <= '0;
            rd_lb_q    <= '0;
            intr_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_emit_q  <= 1'b0;
            s1_pad_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            win_q      <= '0;
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            intr_q  <= retire;
            if (retire) rd_lb_q <= lb_add(rd_lb_q, 1);
            if (en) begin
                s1_vld_q   <= issue;
                s1_emit_q  <= issue && (rc_q >= RW'(EMIT_MIN));
                s1_pad_q   <= rc_q >= RW'(IMG_W);
                s1_last_q  <= issue && (rc_q == RW'(RC_LAST));
                win_q      <= win_d;
                win_vld_q  <= s1_vld_q && s1_emit_q;
                win_last_q <= s1_vld_q && s1_last_q;
            end
        end
    end

    assign o_win_valid = win_vld_q;
    assign o_win_data  = win_q;
    assign o_intr      = intr_q;
    assign o_lines     = lines_q;
    assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_img_window_gen.sv
// Bench for img_window_gen: directed phases with random pixels/readiness,
// windows checked against an array model of the pushed image lines.
module tb_img_window_gen;
    localparam int DW    = 8;
    localparam int IMG_W = 8;
    localparam int K     = 3;
    localparam int NLB   = 4;
    localparam int WW    = K * K * DW;
    localparam int CW    = $clog2(NLB + 1);
`ifdef IMGWIN_ZERO_PAD_EN
    localparam int X0 = 0;
    localparam int NW = IMG_W;
`else
    localparam int X0 = K / 2;
    localparam int NW = IMG_W - K + 1;
`endif

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_in_ready;
    logic          o_win_valid;
    logic [WW-1:0] o_win_data;
    logic          i_win_ready;
    logic          o_intr;
    logic [CW-1:0] o_lines;
    logic          o_ovf;

    img_window_gen #(.DW(DW), .IMG_W(IMG_W), .K(K), .NLB(NLB)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_in_ready(o_in_ready), .o_win_valid(o_win_valid),
        .o_win_data(o_win_data), .i_win_ready(i_win_ready),
        .o_intr(o_intr), .o_lines(o_lines), .o_ovf(o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] pix [16][IMG_W];
    int nlines = 0;
    logic [WW-1:0] got_q [$];
    int rd_ix = 0;
    int intr_cnt = 0;
    int intr_mark = 0;

    always @(negedge clk) begin
        if (rst && o_win_valid && i_win_ready) got_q.push_back(o_win_data);
        if (rst && o_intr) intr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int avail();
        return got_q.size() - rd_ix;
    endfunction

    function automatic logic [WW-1:0] exp_win(input int base, input int x);
        logic [WW-1:0] w;
        int c;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int j = 0; j < K; j++) begin
                c = x - K / 2 + j;
                if (c >= 0 && c < IMG_W) w[(r*K+j)*DW +: DW] = pix[base+r][c];
            end
        end
        return w;
    endfunction

    task automatic check_set(input int base, input string tag);
        logic [WW-1:0] w;
        for (int i = 0; i < NW; i++) begin
            w = 'x;
            if (rd_ix < got_q.size()) begin
                w = got_q[rd_ix];
                rd_ix++;
            end
            chk(tag, w, exp_win(base, X0 + i));
        end
    endtask

    task automatic push_line(input bit rnd, input bit rnd_rdy, input int npix);
        int c;
        int g;
        bit gap;
        logic [DW-1:0] d;
        c = 0;
        g = 0;
        while (c < npix && g < 400) begin
            gap = rnd && ($urandom_range(0, 3) == 0);
            d = rnd ? DW'($urandom) : DW'(nlines * 16 + c);
            if (rnd_rdy) i_win_ready = 1'($urandom);
            if (gap || !o_in_ready) begin
                i_valid = 1'b0;
            end else begin
                i_valid = 1'b1;
                i_data = d;
                pix[nlines][c] = d;
                c++;
            end
            step();
            g++;
        end
        i_valid = 1'b0;
        chk("push_count", c, npix);
        if (npix == IMG_W) nlines++;
    endtask

    task automatic drain(input int n, input bit rnd_rdy, input string tag);
        int g;
        g = 0;
        while (avail() < n && g < 500) begin
            i_win_ready = rnd_rdy ? 1'($urandom) : 1'b1;
            step();
            g++;
        end
        chk(tag, avail(), n);
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_data = '0;
        i_win_ready = 1'b0;
        rst = 1'b0;
        step();
        step();
        rd_ix = got_q.size();
        intr_mark = intr_cnt;
        nlines = 0;
        rst = 1'b1;
        step();
    endtask

    initial begin
        int g;
        rst = 1'b0;
        i_valid = 1'b0;
        i_data = '0;
        i_win_ready = 1'b0;
        step();
        step();
        chk("rst_win_valid", o_win_valid, 0);
        chk("rst_win_data", o_win_data, 0);
        chk("rst_intr", o_intr, 0);
        chk("rst_lines", o_lines, 0);
        chk("rst_ovf", o_ovf, 0);
        chk("rst_in_ready", o_in_ready, 1);
        rst = 1'b1;
        step();
        chk("post_rst_in_ready", o_in_ready, 1);
        chk("post_rst_lines", o_lines, 0);

        // three lines, backpressure on window 3
        i_win_ready = 1'b1;
        intr_mark = intr_cnt;
        for (int l = 0; l < 3; l++) push_line(1'b0, 1'b0, IMG_W);
        g = 0;
        while (!(avail() == 3 && o_win_valid) && g < 100) begin
            step();
            g++;
        end
        chk("bp_reach", avail(), 3);
        i_win_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("bp_valid", o_win_valid, 1);
            chk("bp_hold", o_win_data, exp_win(0, X0 + 3));
        end
        chk("bp_no_accept", avail(), 3);
        drain(NW, 1'b0, "a_count");
        for (int s = 0; s < 4; s++) step();
        check_set(0, "a_win");
        chk("a_no_dup", avail(), 0);
        chk("a_intr", intr_cnt - intr_mark, 1);
        chk("a_lines", o_lines, 2);

        // random pixels, gaps and readiness over three more lines
        intr_mark = intr_cnt;
        for (int l = 0; l < 3; l++) push_line(1'b1, 1'b1, IMG_W);
        drain(3 * NW, 1'b1, "b_count");
        i_win_ready = 1'b1;
        for (int s = 0; s < 6; s++) step();
        check_set(1, "b_win1");
        check_set(2, "b_win2");
        check_set(3, "b_win3");
        chk("b_no_dup", avail(), 0);
        chk("b_intr", intr_cnt - intr_mark, 3);
        chk("b_lines", o_lines, 2);

        // overflow with the read side blocked
        do_reset();
        for (int l = 0; l < 4; l++) push_line(1'b0, 1'b0, IMG_W);
        step();
        chk("ov_lines4", o_lines, 4);
        chk("ov_in_ready", o_in_ready, 0);
        chk("ov_no_ovf_yet", o_ovf, 0);
        for (int c = 0; c < IMG_W; c++) begin
            i_valid = 1'b1;
            i_data = 8'hEE;
            step();
        end
        i_valid = 1'b0;
        chk("ov_ovf", o_ovf, 1);
        chk("ov_lines_hold", o_lines, 4);
        chk("ov_win_valid", o_win_valid, 1);
        chk("ov_win0", o_win_data, exp_win(0, X0));
        for (int s = 0; s < 3; s++) step();
        chk("ov_sticky", o_ovf, 1);
        i_win_ready = 1'b1;
        drain(2 * NW, 1'b0, "ov_count");
        for (int s = 0; s < 4; s++) step();
        check_set(0, "ov_win0set");
        check_set(1, "ov_win1set");
        chk("ov_lines2", o_lines, 2);
        chk("ov_intr", intr_cnt - intr_mark, 2);
        chk("ov_sticky2", o_ovf, 1);

        // asynchronous reset in the middle of a line
        push_line(1'b1, 1'b0, 3);
        rst = 1'b0;
        #1;
        chk("mid_rst_lines", o_lines, 0);
        chk("mid_rst_ovf", o_ovf, 0);
        chk("mid_rst_valid", o_win_valid, 0);
        chk("mid_rst_ready", o_in_ready, 1);
        do_reset();

        // last pixel of line 3 lands on the retire of line 0
        i_win_ready = 1'b1;
        for (int l = 0; l < 3; l++) push_line(1'b0, 1'b0, IMG_W);
        push_line(1'b0, 1'b0, IMG_W - 1);
        g = 0;
        while (!(avail() == NW - 1 && o_win_valid) && g < 100) begin
            step();
            g++;
        end
        chk("co_reach", avail(), NW - 1);
        step();
        i_valid = 1'b1;
        i_data = DW'(nlines * 16 + IMG_W - 1);
        pix[nlines][IMG_W-1] = i_data;
        step();
        i_valid = 1'b0;
        nlines++;
        chk("co_lines", o_lines, 3);
        chk("co_intr_hi", o_intr, 1);
        step();
        chk("co_intr_lo", o_intr, 0);
        chk("co_intr_cnt", intr_cnt - intr_mark, 1);
        check_set(0, "co_win0");
        drain(NW, 1'b0, "co_count1");
        for (int s = 0; s < 4; s++) step();
        check_set(1, "co_win1");
        chk("co_intr_cnt2", intr_cnt - intr_mark, 2);
        chk("co_lines2", o_lines, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
